// File: rtl/hwce_result_writer.sv
// HWCE result write-back: shifts each accumulator to 16 bits and streams two results per 32-bit TCDM port per beat.
// Optional build macro HWCE_RESULT_WRITER_SAT_EN clamps to the int16 range instead of truncating.
module hwce_result_writer #(
  parameter int N_ACCELERATOR_PORT = 8,
  parameter int N_ROW              = 4,
  parameter int N_COL              = 4,
  parameter int NPF                = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start_i,
  input  logic [31:0]                                  base_addr_i,
  input  logic [3:0]                                   shift_i,
  input  logic [N_ROW-1:0][N_COL-1:0][NPF-1:0][31:0]   results_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic [N_ACCELERATOR_PORT-1:0]                tcdm_req_o,
  output logic [N_ACCELERATOR_PORT-1:0]                tcdm_wen_o,
  output logic [N_ACCELERATOR_PORT-1:0][31:0]          tcdm_addr_o,
  output logic [N_ACCELERATOR_PORT-1:0][31:0]          tcdm_wdata_o,
  output logic [N_ACCELERATOR_PORT-1:0][3:0]           tcdm_be_o,
  input  logic [N_ACCELERATOR_PORT-1:0]                tcdm_wait_ni
);

  localparam int NP     = N_ACCELERATOR_PORT;
  localparam int TOTAL  = N_ROW * N_COL * NPF;
  localparam int EPB    = 2 * NP;
  localparam int BEATS  = (TOTAL + EPB - 1) / EPB;
  localparam int PADDED = BEATS * EPB;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = $clog2(PADDED);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [31:0]             base_q, base_d;
  logic [TOTAL-1:0][15:0]  conv_q, conv_d;
  logic [TOTAL-1:0][15:0]  conv_in;
  logic [PADDED-1:0][15:0] padded;
  logic                    done_q, done_d;
  logic                    accept;
  logic [IDX_W-1:0]        idx;

  function automatic logic [15:0] convert(input logic [31:0] acc, input logic [3:0] sh);
`ifdef HWCE_RESULT_WRITER_SAT_EN
    logic signed [31:0] y;
    y = $signed(acc) >>> sh;
    if (y > 32'sd32767)
      return 16'h7FFF;
    else if (y < -32'sd32768)
      return 16'h8000;
    else
      return y[15:0];
`else
    return 16'($signed(acc) >>> sh);
`endif
  endfunction

  always_comb begin
    conv_in = '0;
    for (int r = 0; r < N_ROW; r++) begin
      for (int c = 0; c < N_COL; c++) begin
        for (int f = 0; f < NPF; f++) begin
          conv_in[(r*N_COL+c)*NPF+f] = convert(results_i[r][c][f], shift_i);
        end
      end
    end
  end

  // Zero-pad the captured results so the last beat can index past TOTAL safely.
  always_comb begin
    padded = '0;
    padded[TOTAL-1:0] = conv_q;
  end

  assign accept = &tcdm_wait_ni;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    conv_d  = conv_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WRITE;
          beat_d  = '0;
          base_d  = base_addr_i & 32'hFFFF_FFFC;
          conv_d  = conv_in;
        end
      end
      WRITE: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            beat_d  = '0;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      conv_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      conv_q  <= conv_d;
      done_q  <= done_d;
    end
  end

  // Bus outputs derive only from registered state, so they hold during stalls and drop at once on reset.
  always_comb begin
    tcdm_req_o   = '0;
    tcdm_wen_o   = '1;
    tcdm_addr_o  = '0;
    tcdm_wdata_o = '0;
    tcdm_be_o    = '0;
    idx          = '0;
    if (state_q == WRITE) begin
      tcdm_req_o = '1;
      tcdm_wen_o = '0;
      for (int p = 0; p < NP; p++) begin
        tcdm_addr_o[p] = base_q + 32'(beat_q) * 32'(NP * 4) + 32'(p * 4);
        for (int h = 0; h < 2; h++) begin
          idx = IDX_W'(int'(beat_q) * EPB + 2 * p + h);
          if (int'(idx) < TOTAL) begin
            tcdm_wdata_o[p][16*h +: 16] = padded[idx];
            tcdm_be_o[p][2*h +: 2]      = 2'b11;
          end
        end
      end
    end
  end

  assign busy_o = (state_q == WRITE);
  assign done_o = done_q;

endmodule

// File: tb/tb_hwce_result_writer.sv
// Scoreboard bench for hwce_result_writer: a queue-based reference model predicts every TCDM beat and done pulse.
`timescale 1ns/1ps
module tb_hwce_result_writer;

  localparam int NP    = 8;
  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int NF    = 3;
  localparam int TOTAL = NR * NC * NF;
  localparam int EPB   = 2 * NP;
  localparam int BEATS = (TOTAL + EPB - 1) / EPB;

  typedef struct {
    logic [NP-1:0][31:0] addr;
    logic [NP-1:0][31:0] wdata;
    logic [NP-1:0][3:0]  be;
  } beat_t;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          startI;
  logic [31:0]                   baseAddrI;
  logic [3:0]                    shiftI;
  logic [NR-1:0][NC-1:0][NF-1:0][31:0] resultsI;
  logic                          busy, done;
  logic [NP-1:0]                 req, wen, waitNi;
  logic [NP-1:0][31:0]           addr, wdata;
  logic [NP-1:0][3:0]            be;

  logic                          start2, busy2, done2;
  logic [0:0][2:0][0:0][31:0]    results2;
  logic [1:0]                    req2, wen2, wait2;
  logic [1:0][31:0]              addr2, wdata2;
  logic [1:0][3:0]               be2;

  beat_t expQ[$];
  logic  expDone;
  int    nChecks = 0;
  int    nFails  = 0;

  hwce_result_writer dut (
    .clk(clk), .rst(rst), .start_i(startI), .base_addr_i(baseAddrI), .shift_i(shiftI),
    .results_i(resultsI), .busy_o(busy), .done_o(done), .tcdm_req_o(req), .tcdm_wen_o(wen),
    .tcdm_addr_o(addr), .tcdm_wdata_o(wdata), .tcdm_be_o(be), .tcdm_wait_ni(waitNi)
  );

  hwce_result_writer #(.N_ACCELERATOR_PORT(2), .N_ROW(1), .N_COL(3), .NPF(1)) dutSmall (
    .clk(clk), .rst(rst), .start_i(start2), .base_addr_i(32'h0000_0040), .shift_i(4'd0),
    .results_i(results2), .busy_o(busy2), .done_o(done2), .tcdm_req_o(req2), .tcdm_wen_o(wen2),
    .tcdm_addr_o(addr2), .tcdm_wdata_o(wdata2), .tcdm_be_o(be2), .tcdm_wait_ni(wait2)
  );

  always #5 clk = ~clk;

  // Floor-divide by 2^shift, then clamp or wrap to 16 bits.
  function automatic logic [15:0] refConvert(logic [31:0] acc, int sh);
    longint v, d, q;
    v = longint'($signed(acc));
    d = longint'(1) << sh;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
`ifdef HWCE_RESULT_WRITER_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  function automatic void pushTransfer();
    beat_t bt [BEATS];
    int r, c, f, b, p, h;
    for (int i = 0; i < BEATS; i++) begin
      for (int k = 0; k < NP; k++) begin
        bt[i].addr[k]  = (baseAddrI & 32'hFFFF_FFFC) + 32'(32 * i + 4 * k);
        bt[i].wdata[k] = '0;
        bt[i].be[k]    = '0;
      end
    end
    for (int e = 0; e < TOTAL; e++) begin
      r = e / (NC * NF);
      c = (e / NF) % NC;
      f = e % NF;
      b = e / EPB;
      p = (e / 2) % NP;
      h = e % 2;
      bt[b].wdata[p][16*h +: 16] = refConvert(resultsI[r][c][f], int'(shiftI));
      bt[b].be[p][2*h +: 2]      = 2'b11;
    end
    for (int i = 0; i < BEATS; i++) expQ.push_back(bt[i]);
  endfunction

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: idle launches on start, busy pops one beat per fully granted edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
      expDone = 1'b0;
    end else if (expQ.size() > 0) begin
      expDone = 1'b0;
      if (&waitNi) begin
        void'(expQ.pop_front());
        if (expQ.size() == 0) expDone = 1'b1;
      end
    end else begin
      expDone = 1'b0;
      if (startI) pushTransfer();
    end
  end

  task automatic checkOutput();
    logic active;
    active = (expQ.size() > 0);
    checkValue("busy", 32'(busy), 32'(active));
    checkValue("done", 32'(done), 32'(expDone));
    checkValue("req", 32'(req), active ? 32'hFF : 32'h0);
    checkValue("wen", 32'(wen), active ? 32'h0 : 32'hFF);
    if (active) begin
      for (int p = 0; p < NP; p++) begin
        checkValue($sformatf("addr[%0d]", p), addr[p], expQ[0].addr[p]);
        checkValue($sformatf("wdata[%0d]", p), wdata[p], expQ[0].wdata[p]);
        checkValue($sformatf("be[%0d]", p), 32'(be[p]), 32'(expQ[0].be[p]));
      end
    end
  endtask

  // Monitor samples on the falling edge, midway between input changes and the next active edge.
  always @(negedge clk) checkOutput();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic [31:0] base, logic [3:0] sh);
    baseAddrI = base;
    shiftI    = sh;
    startI    = 1'b1;
    tick();
    startI    = 1'b0;
  endtask

  task automatic waitIdle(int budget, bit randomize);
    int i;
    for (i = 0; i < budget; i++) begin
      if (expQ.size() == 0 && !expDone) break;
      if (randomize) begin
        for (int k = 0; k < NP; k++) waitNi[k] = ($urandom_range(7) != 0);
        startI = ($urandom_range(15) == 0);
      end else begin
        waitNi = '1;
      end
      tick();
    end
    waitNi = '1;
    startI = 1'b0;
    checkValue("idle_timeout", 32'(i == budget), 32'h0);
  endtask

  task automatic fillIndex();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        for (int f = 0; f < NF; f++)
          resultsI[r][c][f] = 32'((r * NC + c) * NF + f);
  endtask

  initial begin
    rst = 1'b1; startI = 1'b0; baseAddrI = '0; shiftI = '0; resultsI = '0; waitNi = '1;
    start2 = 1'b0; results2 = '0; wait2 = '1;
    #12;
    checkValue("rst_req", 32'(req), 32'h0);
    checkValue("rst_wen", 32'(wen), 32'hFF);
    checkValue("rst_addr0", addr[0], 32'h0);
    checkValue("rst_wdata0", wdata[0], 32'h0);
    checkValue("rst_be", 32'(be), 32'h0);
    checkValue("rst_busy", 32'(busy), 32'h0);
    checkValue("rst_done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] index pattern, no stalls");
    fillIndex();
    applyStimulus(32'h0000_1000, 4'd0);
    checkValue("first_wdata0", wdata[0], 32'h0001_0000);
    checkValue("first_addr7", addr[7], 32'h0000_101C);
    waitIdle(20, 1'b0);

    $display("[TB] port 3 stall during beat 1");
    applyStimulus(32'h0000_1000, 4'd0);
    tick();
    waitNi[3] = 1'b0;
    tick();
    tick();
    waitNi = '1;
    waitIdle(20, 1'b0);

    $display("[TB] conversion corner values");
    resultsI = '0;
    resultsI[0][0][0] = 32'h0001_0000;
    resultsI[0][0][1] = 32'h8000_0000;
    resultsI[1][2][2] = 32'h7FFF_FFFF;
    resultsI[3][3][2] = 32'hFFFF_FFFF;
    applyStimulus(32'h0000_2002, 4'd0);
`ifdef HWCE_RESULT_WRITER_SAT_EN
    checkValue("sat_e0", 32'(wdata[0][15:0]), 32'h7FFF);
`else
    checkValue("trunc_e0", 32'(wdata[0][15:0]), 32'h0000);
`endif
    checkValue("align_addr0", addr[0], 32'h0000_2000);
    waitIdle(20, 1'b0);
    resultsI[0][0][0] = 32'hFFFF_0000;
    applyStimulus(32'h0000_2000, 4'd4);
    checkValue("shift4_e0", 32'(wdata[0][15:0]), 32'hF000);
    waitIdle(20, 1'b0);

    $display("[TB] start pulse during beat 1 is ignored");
    fillIndex();
    applyStimulus(32'h0000_3000, 4'd1);
    tick();
    startI = 1'b1;
    tick();
    startI = 1'b0;
    waitIdle(20, 1'b0);

    $display("[TB] start held high relaunches");
    baseAddrI = 32'h0000_4000;
    startI = 1'b1;
    repeat (5) tick();
    checkValue("relaunch_req", 32'(req), 32'hFF);
    startI = 1'b0;
    waitIdle(20, 1'b0);

    $display("[TB] reset during beat 1");
    applyStimulus(32'h0000_5000, 4'd0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkValue("abort_req", 32'(req), 32'h0);
    checkValue("abort_busy", 32'(busy), 32'h0);
    checkValue("abort_done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(32'h0000_5000, 4'd0);
    checkValue("restart_addr0", addr[0], 32'h0000_5000);
    waitIdle(20, 1'b0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 25; t++) begin
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++)
          for (int f = 0; f < NF; f++)
            case ($urandom_range(2))
              0:       resultsI[r][c][f] = $urandom;
              1:       resultsI[r][c][f] = $urandom & 32'h0007_FFFF;
              default: resultsI[r][c][f] = $urandom | 32'hFFF8_0000;
            endcase
      applyStimulus($urandom, 4'($urandom_range(15)));
      waitIdle(400, 1'b1);
    end

    $display("[TB] small configuration with unused halves");
    results2[0][0][0] = 32'h11;
    results2[0][1][0] = 32'h22;
    results2[0][2][0] = 32'h33;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checkValue("small_req", 32'(req2), 32'h3);
    checkValue("small_wen", 32'(wen2), 32'h0);
    checkValue("small_busy", 32'(busy2), 32'h1);
    checkValue("small_addr0", addr2[0], 32'h40);
    checkValue("small_addr1", addr2[1], 32'h44);
    checkValue("small_wdata0", wdata2[0], 32'h0022_0011);
    checkValue("small_wdata1", wdata2[1], 32'h0000_0033);
    checkValue("small_be0", 32'(be2[0]), 32'hF);
    checkValue("small_be1", 32'(be2[1]), 32'h3);
    tick();
    checkValue("small_done", 32'(done2), 32'h1);
    checkValue("small_req_off", 32'(req2), 32'h0);
    tick();
    checkValue("small_done_off", 32'(done2), 32'h0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
